inst_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the processor's Controller/ALUController/data_path.

---
 rtl/inst_fetch_unit_pkg.sv | 25 ++
 rtl/inst_fetch_unit_if.sv | 36 +++
 rtl/inst_fetch_unit_fifo.sv | 60 ++++++
 rtl/inst_fetch_unit.sv | 92 +++++++++
 tb/tb_inst_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - instruction widths, field slice positions and queue entry type for the fetch stage
package inst_fetch_unit_pkg;

    localparam int INST_W = 32;
    localparam int XLEN   = 32;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - imem request/response, redirect and instruction handshake bundle
interface inst_fetch_unit_if;
    import inst_fetch_unit_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [XLEN-1:0]   inst_pc;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc, opcode, funct3, funct7,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc, opcode, funct3, funct7,
        output inst_ready
    );

endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// rtl/inst_fetch_unit_fifo.sv - in-order {pc,inst} queue; flush wins over push/pop, head reads 0 when empty
module inst_fetch_unit_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;

    // DEPTH is a power of two, so pointers wrap on their own
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch PC, credit-gated imem requests, stale-response drop and pre-sliced instruction output
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    inst_fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credit_used;
    logic             req_fire;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] resp_dec;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    // Every in-flight request reserves a queue slot, so a returning word always fits
    assign credit_used        = {1'b0, count} + {1'b0, outstanding};
    assign bus.imem_req_valid = !reset && !bus.redirect_valid && (credit_used < DEPTH_LIM);
    assign bus.imem_req_addr  = fetch_pc;

    assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_dec   = CNT_W'(bus.imem_resp_valid);
    assign push       = bus.imem_resp_valid && (drop == '0) && !bus.redirect_valid;
    assign pop        = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    assign push_entry = '{pc: resp_pc, inst: bus.imem_resp_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (bus.redirect_valid) begin
            // Whatever is still in flight after this edge belongs to the old path
            fetch_pc    <= word_align(bus.redirect_pc);
            resp_pc     <= word_align(bus.redirect_pc);
            outstanding <= outstanding - resp_dec;
            drop        <= outstanding - resp_dec;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            case ({req_fire, bus.imem_resp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (bus.imem_resp_valid) begin
                if (drop != '0) drop <= drop - 1'b1;
                else            resp_pc <= resp_pc + XLEN'(4);
            end
        end
    end

    inst_fetch_unit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign bus.inst_valid = !empty;
    assign bus.inst_data  = head.inst;
    assign bus.inst_pc    = head.pc;
    assign bus.opcode     = head.inst[OPCODE_MSB:OPCODE_LSB];
    assign bus.funct3     = head.inst[FUNCT3_MSB:FUNCT3_LSB];
    assign bus.funct7     = head.inst[FUNCT7_MSB:FUNCT7_LSB];

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard bench for inst_fetch_unit with a variable-latency imem model
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    inst_fetch_unit_if bus();

    inst_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    int n_req = 0;
    int lat = 1;
    bit rand_lat = 1'b0;
    int cyc = 0;
    logic [63:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int pend_due[$];

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return (pc * 32'h0101_0101) ^ 32'hC0DE_0033;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_stream(input logic [31:0] start, input int n);
        logic [31:0] pc;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            pc = start + 32'(4 * i);
            exp_q.push_back({pc, word_of(pc)});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        tick(3);
        n_pop = 0;
        n_req = 0;
        reset = 1'b0;
    endtask

    // imem model: in-order responses, each no earlier than its latency
    initial begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data = '0;
            end else begin
                if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data = word_of(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    bus.imem_resp_valid = 1'b0;
                    bus.imem_resp_data = 32'hDEAD_BEEF;
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    n_req++;
                    pend_addr.push_back(bus.imem_req_addr);
                    pend_due.push_back(cyc + (rand_lat ? int'($urandom_range(1, 5)) : lat));
                end
            end
        end
    end

    // monitor: every consumed instruction is checked against the scoreboard head
    initial begin
        logic [63:0] e;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (!reset && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got pc %h expected no instruction", bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    w = e[31:0];
                    check("sb_pc", bus.inst_pc, e[63:32]);
                    check("sb_data", bus.inst_data, w);
                    check("sb_fields", {15'b0, bus.funct7, bus.funct3, bus.opcode},
                          {15'b0, w[31:25], w[14:12], w[6:0]});
                end
            end
        end
    end

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        tick(2);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_inst_data", bus.inst_data, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);

        // 1: streaming, one instruction per cycle
        reset = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        lat = 1;
        expect_stream(32'h0, 64);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
            check("t1_req_addr", bus.imem_req_addr, 32'(4 * i));
        end
        tick(5);
        begin
            int p0;
            p0 = n_pop;
            tick(10);
            check("t1_throughput", 32'(n_pop - p0), 32'd10);
        end

        // 2: consumer stalled, credit limit
        do_reset();
        bus.imem_req_ready = 1'b1;
        expect_stream(32'h0, 64);
        tick(10);
        check("t2_req_count", 32'(n_req), 32'd4);
        check("t2_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("t2_inst_valid", 32'(bus.inst_valid), 32'd1);
        check("t2_head_pc", bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        tick(1);
        check("t2_resume_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t2_resume_addr", bus.imem_req_addr, 32'h10);
        tick(10);

        // 3: redirect with three requests in flight
        do_reset();
        lat = 5;
        expect_stream(32'h0, 64);
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        tick(3);
        check("t3_inflight", 32'(n_req), 32'd3);
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        expect_stream(32'h100, 64);
        #1;
        check("t3_no_req_in_redirect", 32'(bus.imem_req_valid), 32'd0);
        tick(1);
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        #1;
        check("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t3_req_addr", bus.imem_req_addr, 32'h100);
        tick(30);
        check("t3_progress", 32'(n_pop >= 8), 32'd1);

        // 4: redirect coinciding with a response and a pop
        do_reset();
        lat = 1;
        expect_stream(32'h0, 64);
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        tick(8);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        expect_stream(32'h200, 64);
        @(negedge clk);
        #1;
        check("t4_resp_same_cycle", 32'(bus.imem_resp_valid), 32'd1);
        check("t4_pop_same_cycle", 32'(bus.inst_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        #1;
        check("t4_flushed", 32'(bus.inst_valid), 32'd0);
        check("t4_req_addr", bus.imem_req_addr, 32'h200);
        tick(10);
        check("t4_progress", 32'(n_pop >= 8), 32'd1);

        // 5: random request backpressure, latency and consumer stalls
        do_reset();
        rand_lat = 1'b1;
        expect_stream(32'h0, 400);
        for (int i = 0; i < 300; i++) begin
            bus.imem_req_ready = 1'($urandom_range(0, 1));
            bus.inst_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        bus.imem_req_ready = 1'b0;
        bus.inst_ready = 1'b1;
        tick(30);
        check("t5_no_loss", 32'(n_pop), 32'(n_req));
        check("t5_progress", 32'(n_pop >= 30), 32'd1);
        check("t5_drained", 32'(bus.inst_valid), 32'd0);
        rand_lat = 1'b0;

        // 6: reset with two requests outstanding and a non-empty queue
        do_reset();
        lat = 2;
        expect_stream(32'h0, 64);
        bus.imem_req_ready = 1'b1;
        tick(4);
        check("t6_pre_valid", 32'(bus.inst_valid), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("t6_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("t6_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("t6_inst_data", bus.inst_data, 32'd0);
        tick(2);
        n_pop = 0;
        reset = 1'b0;
        expect_stream(32'h0, 64);
        bus.inst_ready = 1'b1;
        #1;
        check("t6_req_valid_after", 32'(bus.imem_req_valid), 32'd1);
        check("t6_req_addr_after", bus.imem_req_addr, 32'h0);
        tick(20);
        check("t6_progress", 32'(n_pop >= 10), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
